datmem_arbiter: RTL and testbench

- Shares the single byte-wide, 32-entry data memory between two requesters: the processor load/store port (cpu) and a loader/debug DMA port (dma).
- Each 32-bit word access is serialized into 4 byte beats, big-endian: most significant byte at the lowest address, which matches the processor's byte ordering.
- Ties are resolved by alternating priority between the two ports.
- The block sits between the datapath's memory address/data nets and the data memory array, and drives the stall-free completion handshake back to each requester.

---
 rtl/datmem_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_datmem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datmem_arbiter.sv
// Two-port arbiter for the byte-wide data memory: serializes cpu/dma 32-bit
// word accesses into four big-endian byte beats with alternating tie priority.
module datmem_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic [31:0]       dma_rdata,
    output logic              dma_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [1:0]        beat_r;
    logic              last_grant_r;
    logic              xfer_we_r;
    logic [ADDR_W-1:0] xfer_addr_r;
    logic [31:0]       xfer_wdata_r;
    logic [23:0]       asm_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_we_r;
    logic [7:0]        mem_wdata_r;
    logic [31:0]       cpu_rdata_r;
    logic [31:0]       dma_rdata_r;
    logic              cpu_done_r;
    logic              dma_done_r;
    logic              busy_r;

    logic              grant_s;
    logic              grant_port_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0]       sel_wdata_s;

    // Beat 0 carries the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Arbitration: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        grant_s      = 1'b0;
        grant_port_s = 1'b0;
        if (cpu_req && dma_req) begin
            grant_s      = 1'b1;
            grant_port_s = ~last_grant_r;
        end else if (cpu_req) begin
            grant_s      = 1'b1;
            grant_port_s = 1'b0;
        end else if (dma_req) begin
            grant_s      = 1'b1;
            grant_port_s = 1'b1;
        end else begin
            grant_s      = 1'b0;
            grant_port_s = 1'b0;
        end
    end

    // Request fields of the port that wins this cycle.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = 32'h0000_0000;
        if (grant_port_s) begin
            sel_we_s    = dma_we;
            sel_addr_s  = dma_addr;
            sel_wdata_s = dma_wdata;
        end else begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_next_s = XFER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            XFER: begin
                if (beat_r == 2'd3) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = XFER;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: latch the granted request, drive each beat, assemble loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_r       <= 2'd0;
            last_grant_r <= 1'b1;
            xfer_we_r    <= 1'b0;
            xfer_addr_r  <= {ADDR_W{1'b0}};
            xfer_wdata_r <= 32'h0000_0000;
            asm_r        <= 24'h00_0000;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_we_r     <= 1'b0;
            mem_wdata_r  <= 8'h00;
            cpu_rdata_r  <= 32'h0000_0000;
            dma_rdata_r  <= 32'h0000_0000;
            cpu_done_r   <= 1'b0;
            dma_done_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            cpu_done_r <= 1'b0;
            dma_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        last_grant_r <= grant_port_s;
                        beat_r       <= 2'd0;
                        busy_r       <= 1'b1;
                        xfer_we_r    <= sel_we_s;
                        xfer_addr_r  <= sel_addr_s;
                        xfer_wdata_r <= sel_wdata_s;
                        mem_addr_r   <= sel_addr_s;
                        mem_we_r     <= sel_we_s;
                        mem_wdata_r  <= sel_we_s ? sel_wdata_s[31:24] : 8'h00;
                    end else begin
                        busy_r      <= 1'b0;
                        mem_addr_r  <= {ADDR_W{1'b0}};
                        mem_we_r    <= 1'b0;
                        mem_wdata_r <= 8'h00;
                    end
                end
                XFER: begin
                    asm_r <= {asm_r[15:0], mem_rdata};
                    if (beat_r == 2'd3) begin
                        mem_addr_r  <= {ADDR_W{1'b0}};
                        mem_we_r    <= 1'b0;
                        mem_wdata_r <= 8'h00;
                        // Loaded word appears together with the done pulse.
                        if (!xfer_we_r && last_grant_r) begin
                            dma_rdata_r <= {asm_r, mem_rdata};
                        end else if (!xfer_we_r) begin
                            cpu_rdata_r <= {asm_r, mem_rdata};
                        end else begin
                            asm_r <= {asm_r[15:0], mem_rdata};
                        end
                        if (last_grant_r) begin
                            dma_done_r <= 1'b1;
                        end else begin
                            cpu_done_r <= 1'b1;
                        end
                    end else begin
                        beat_r      <= beat_r + 2'd1;
                        mem_addr_r  <= xfer_addr_r + ADDR_W'(beat_r) + ADDR_W'(1);
                        mem_wdata_r <= xfer_we_r ? byte_sel(xfer_wdata_r, beat_r + 2'd1) : 8'h00;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r   <= 1'b0;
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_rdata = cpu_rdata_r;
    assign dma_rdata = dma_rdata_r;
    assign cpu_done  = cpu_done_r;
    assign dma_done  = dma_done_r;
    assign busy      = busy_r;
    assign owner     = last_grant_r;

endmodule

// File: tb/tb_datmem_arbiter.sv
// Bench for datmem_arbiter: transaction-schedule reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_datmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [4:0]  cpu_addr, dma_addr, mem_addr;
    logic [31:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
    logic        cpu_done, dma_done, mem_we, busy, owner;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_clr;
    logic [7:0]  env_mem [32];

    int pass_cnt = 0;
    int total_cnt = 0;

    datmem_arbiter #(.ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_done(dma_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 7 + 53);
    endfunction

    // Data memory array seen by the arbiter.
    assign mem_rdata = env_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= init_byte(i);
        end else if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a granted transfer at edge g owns cycles g..g+3 (beats),
    // g+4 (done); the next grant may happen at edge g+6.
    int          ecnt = 0;
    int          free_at = 0;
    int          g = 0;
    int          md;
    int          cd;
    bit          act = 1'b0;
    bit          last_g = 1'b1;
    bit          a_port, a_we, p;
    logic [4:0]  a_addr, ma, ea;
    logic [31:0] a_wdata, w;
    logic [7:0]  eb;
    logic [31:0] ref_rd [2];
    logic [7:0]  ref_mem [32];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            act = 1'b0;
            last_g = 1'b1;
            free_at = 0;
            ref_rd[0] = 32'h0;
            ref_rd[1] = 32'h0;
            if (mem_clr) for (int i = 0; i < 32; i++) ref_mem[i] = init_byte(i);
        end else begin
            ecnt = ecnt + 1;
            if (act) begin
                md = ecnt - g;
                if (a_we && md >= 1 && md <= 4) begin
                    ma = a_addr + 5'(md - 1);
                    ref_mem[ma] = 8'(a_wdata >> (32 - 8 * md));
                end
                if (!a_we && md == 4) begin
                    w = 32'h0;
                    for (int k = 0; k < 4; k++) begin
                        ma = a_addr + 5'(k);
                        w = {w[23:0], ref_mem[ma]};
                    end
                    ref_rd[a_port] = w;
                end
                if (md >= 5) act = 1'b0;
            end
            if (!act && ecnt >= free_at && (cpu_req || dma_req)) begin
                p = (cpu_req && dma_req) ? !last_g : dma_req;
                act = 1'b1;
                g = ecnt;
                free_at = ecnt + 6;
                last_g = p;
                a_port = p;
                a_we = p ? dma_we : cpu_we;
                a_addr = p ? dma_addr : cpu_addr;
                a_wdata = p ? dma_wdata : cpu_wdata;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            cd = act ? (ecnt - g) : 99;
            chk("busy", 32'(busy), (cd <= 4) ? 32'd1 : 32'd0);
            chk("mem_we", 32'(mem_we), (cd <= 3 && a_we) ? 32'd1 : 32'd0);
            if (cd <= 3) begin
                ea = a_addr + 5'(cd);
                eb = a_we ? 8'(a_wdata >> (24 - 8 * cd)) : 8'h00;
                chk("mem_addr", 32'(mem_addr), 32'(ea));
                chk("mem_wdata", 32'(mem_wdata), 32'(eb));
            end
            chk("cpu_done", 32'(cpu_done), (cd == 4 && !a_port) ? 32'd1 : 32'd0);
            chk("dma_done", 32'(dma_done), (cd == 4 && a_port) ? 32'd1 : 32'd0);
            chk("done_excl", 32'(cpu_done & dma_done), 32'd0);
            chk("owner", 32'(owner), 32'(last_g));
            chk("cpu_rdata", cpu_rdata, ref_rd[0]);
            chk("dma_rdata", dma_rdata, ref_rd[1]);
        end
    end

    task automatic set_port(input bit port, input bit req, input bit we,
                            input logic [4:0] addr, input logic [31:0] wd);
        if (port) begin
            dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
    endtask

    // One transfer on one port; req dropped in the done cycle or at drop_at.
    task automatic run_txn(input bit port, input bit we, input logic [4:0] addr,
                           input logic [31:0] wd, input int drop_at, output logic [31:0] rd);
        bit ok;
        ok = 1'b0;
        rd = 32'h0;
        @(negedge clk);
        set_port(port, 1'b1, we, addr, wd);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (port ? dma_done : cpu_done) begin
                rd = port ? dma_rdata : cpu_rdata;
                chk("other_done", 32'(port ? cpu_done : dma_done), 32'd0);
                chk("done_latency", 32'(c), 32'd4);
                ok = 1'b1;
                break;
            end
            if (c == drop_at) begin
                if (port) dma_req = 1'b0; else cpu_req = 1'b0;
            end
        end
        if (port) dma_req = 1'b0; else cpu_req = 1'b0;
        chk("txn_timeout", 32'(ok), 32'd1);
    endtask

    logic [31:0] rd;
    logic [7:0]  old10, old11;
    bit          found;
    int          n;
    int          dcyc [3];
    bit          dwho [3];
    bit          down [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        mem_clr = 1'b0;
        #1 reset = 1'b0;

        // Store then load on the cpu port.
        run_txn(1'b0, 1'b1, 5'd4, 32'hA1B2C3D4, -1, rd);
        chk("st_mem4", 32'(env_mem[4]), 32'hA1);
        chk("st_mem5", 32'(env_mem[5]), 32'hB2);
        chk("st_mem6", 32'(env_mem[6]), 32'hC3);
        chk("st_mem7", 32'(env_mem[7]), 32'hD4);
        run_txn(1'b0, 1'b0, 5'd4, 32'h0, -1, rd);
        chk("ld_cpu", rd, 32'hA1B2C3D4);
        chk("ld_dma_untouched", dma_rdata, 32'h0);

        // Address wrap on the dma port.
        run_txn(1'b1, 1'b1, 5'd30, 32'h11223344, -1, rd);
        chk("wr_mem30", 32'(env_mem[30]), 32'h11);
        chk("wr_mem31", 32'(env_mem[31]), 32'h22);
        chk("wr_mem0", 32'(env_mem[0]), 32'h33);
        chk("wr_mem1", 32'(env_mem[1]), 32'h44);
        run_txn(1'b1, 1'b0, 5'd30, 32'h0, -1, rd);
        chk("wr_ld_dma", rd, 32'h11223344);

        // Contention from reset: both ports request continuously.
        @(negedge clk);
        reset = 1'b1;
        set_port(1'b0, 1'b1, 1'b0, 5'd4, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 5'd30, 32'h0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (cpu_done || dma_done) begin
                dcyc[n] = c; dwho[n] = dma_done; down[n] = owner;
                if (n == 2) begin cpu_req = 1'b0; dma_req = 1'b0; end
                n++;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("cont_count", 32'(n), 32'd3);
        chk("cont_g0", 32'(dwho[0]), 32'd0);
        chk("cont_g1", 32'(dwho[1]), 32'd1);
        chk("cont_g2", 32'(dwho[2]), 32'd0);
        chk("cont_own1", 32'(down[1]), 32'd1);
        chk("cont_gap01", 32'(dcyc[1] - dcyc[0]), 32'd6);
        chk("cont_gap12", 32'(dcyc[2] - dcyc[1]), 32'd6);
        chk("cont_ld_cpu", cpu_rdata, 32'hA1B2C3D4);

        // Reset during beat 2 of a cpu store.
        repeat (3) @(negedge clk);
        old10 = env_mem[10]; old11 = env_mem[11];
        set_port(1'b0, 1'b1, 1'b1, 5'd8, 32'hDEADBEEF);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 5'd10) begin found = 1'b1; break; end
        end
        chk("mrst_beat2_seen", 32'(found), 32'd1);
        #2 reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("mrst_mem_we", 32'(mem_we), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(cpu_done), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("mrst_mem8", 32'(env_mem[8]), 32'hDE);
        chk("mrst_mem9", 32'(env_mem[9]), 32'hAD);
        chk("mrst_mem10", 32'(env_mem[10]), 32'(old10));
        chk("mrst_mem11", 32'(env_mem[11]), 32'(old11));

        // dma load with req dropped during beat 1.
        run_txn(1'b1, 1'b0, 5'd4, 32'h0, 1, rd);
        chk("drop_ld", rd, 32'hA1B2C3D4);
        repeat (10) begin
            @(negedge clk);
            chk("drop_no_second", 32'(busy), 32'd0);
        end

        // Random traffic; fields may change while pending.
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (cpu_done) cpu_req = 1'b0;
            else if (!cpu_req && $urandom_range(3) == 0)
                set_port(1'b0, 1'b1, 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
            else if (cpu_req && $urandom_range(7) == 0)
                set_port(1'b0, 1'b1, 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
            if (dma_done) dma_req = 1'b0;
            else if (!dma_req && $urandom_range(3) == 0)
                set_port(1'b1, 1'b1, 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
            else if (dma_req && $urandom_range(7) == 0)
                set_port(1'b1, 1'b1, 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (15) @(negedge clk);
        for (int i = 0; i < 32; i++) chk("final_mem", 32'(env_mem[i]), 32'(ref_mem[i]));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
